// File: rtl/dmem_bridge_pkg.sv
// Shared definitions for the data-memory bridge: FSM state encoding and the
// read-data fill value returned when a memory access times out.
package dmem_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [31:0] TIMEOUT_FILL = 32'hDEAD_BEEF;

endpackage

// File: rtl/dmem_bridge.sv
// Bridges single-cycle core load/store requests onto a req/ack memory port,
// stalling the core until completion. Optional DMEM_BRIDGE_TIMEOUT_EN adds an ack timeout.
module dmem_bridge
  import dmem_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        err_misaligned,
`ifdef DMEM_BRIDGE_TIMEOUT_EN
  output logic        err_timeout,
`endif
  output logic [1:0]  dbg_state
);

  // Memory handshake: mem_req stays high with mem_we/mem_addr/mem_wdata stable
  // from the first WAIT cycle until the cycle mem_ack=1; that cycle completes the
  // transfer. mem_ack seen in any other state is ignored.

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("dmem_bridge: TIMEOUT_CYCLES must be in 1..65535");
  end

  state_t state;
  state_t state_nxt;
  logic   req_any;
  logic   aligned;
  logic   accept;
  logic   timeout_hit;

  assign req_any   = cpu_read | cpu_write;
  assign aligned   = (cpu_addr[1:0] == 2'b00);
  assign accept    = (state == IDLE) && req_any && aligned;
  assign dbg_state = state;

`ifdef DMEM_BRIDGE_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wait_cnt;

  // wait_cnt holds the number of WAIT cycles already spent before this one.
  assign timeout_hit = (state == WAIT) && !mem_ack && (wait_cnt == TIMEOUT_LAST);

  always_ff @(posedge clk) begin
    if (nrst) begin
      wait_cnt    <= 16'd0;
      err_timeout <= 1'b0;
    end else begin
      if (accept)
        wait_cnt <= 16'd0;
      else if (state == WAIT)
        wait_cnt <= wait_cnt + 16'd1;
      err_timeout <= timeout_hit;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_nxt      = state;
    stall          = 1'b0;
    mem_req        = 1'b0;
    err_misaligned = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = WAIT;
          stall     = 1'b1;
        end else if (req_any) begin
          err_misaligned = 1'b1;
        end
      end
      WAIT: begin
        stall   = 1'b1;
        mem_req = 1'b1;
        if (mem_ack || timeout_hit)
          state_nxt = DONE;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Reset overrides everything the core or memory can see this cycle.
    if (nrst) begin
      stall          = 1'b0;
      mem_req        = 1'b0;
      err_misaligned = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      state     <= IDLE;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      cpu_rdata <= 32'd0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        mem_we    <= cpu_write;
        mem_addr  <= {cpu_addr[31:2], 2'b00};
        mem_wdata <= cpu_wdata;
      end
      if (state == WAIT && !mem_we) begin
        if (mem_ack)
          cpu_rdata <= mem_rdata;
        else if (timeout_hit)
          cpu_rdata <= TIMEOUT_FILL;
      end
    end
  end

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed-plus-random bench for dmem_bridge: a transaction-level memory model
// and an expected-transaction queue check the core and memory sides cycle by cycle.
module tb_dmem_bridge;

`ifdef DMEM_BRIDGE_TIMEOUT_EN
  localparam int TO_CYC  = 4;
  localparam int MAX_ACK = 3;
`else
  localparam int TO_CYC  = 255;
  localparam int MAX_ACK = 5;
`endif

  logic        clk = 1'b0;
  logic        nrst;
  logic        cpu_read, cpu_write;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        stall, mem_req, mem_we, mem_ack, err_misaligned;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  dbg_state;
`ifdef DMEM_BRIDGE_TIMEOUT_EN
  logic        err_timeout;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] model_rdata;
  logic [64:0] exp_q[$];

  dmem_bridge #(.TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk(clk), .nrst(nrst),
    .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .err_misaligned(err_misaligned),
`ifdef DMEM_BRIDGE_TIMEOUT_EN
    .err_timeout(err_timeout),
`endif
    .dbg_state(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // scoreboard: every completed memory handshake must match the oldest expected access
  always @(negedge clk) begin
    if (mem_req === 1'b1 && mem_ack === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $error("FAIL txn_unexpected: observed we=%b addr=%h wdata=%h expected none",
               mem_we, mem_addr, mem_wdata);
      end else begin
        logic [64:0] e;
        e = exp_q.pop_front();
        assert ({mem_we, mem_addr, mem_wdata} === e) else begin
          n_err++;
          $error("FAIL txn: observed %h expected %h", {mem_we, mem_addr, mem_wdata}, e);
        end
      end
    end
  end

  // driver: one aligned access; ack arrives in WAIT cycle number ack_at,
  // or is held high throughout when stuck=1
  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdat,
                        input int ack_at, input bit stuck);
    exp_q.push_back({wr, addr, wdata});
    cpu_read  = rd;
    cpu_write = wr;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    for (int c = 0; c <= ack_at + 1; c++) begin
      mem_ack   = stuck || (c == ack_at);
      mem_rdata = (c == ack_at) ? rdat : $urandom;
      @(negedge clk);
      chk("stall", 32'(stall), 32'(c <= ack_at));
      chk("mem_req", 32'(mem_req), 32'(c >= 1 && c <= ack_at));
      if (c >= 1 && c <= ack_at) begin
        chk("mem_we", 32'(mem_we), 32'(wr));
        chk("mem_addr", mem_addr, addr);
        chk("mem_wdata", mem_wdata, wdata);
      end
      if (c == ack_at + 1 && rd && !wr) model_rdata = rdat;
      chk("cpu_rdata", cpu_rdata, model_rdata);
      @(posedge clk); #1;
    end
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
    mem_ack   = 1'b0;
  endtask

  task automatic misaligned(input logic rd, input logic wr, input logic [31:0] addr);
    cpu_read  = rd;
    cpu_write = wr;
    cpu_addr  = addr;
    cpu_wdata = $urandom;
    mem_ack   = 1'b1;
    @(negedge clk);
    chk("mis_err", 32'(err_misaligned), 32'd1);
    chk("mis_stall", 32'(stall), 32'd0);
    chk("mis_req", 32'(mem_req), 32'd0);
    @(posedge clk); #1;
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
    mem_ack   = 1'b0;
    @(negedge clk);
    chk("mis_err_clr", 32'(err_misaligned), 32'd0);
    chk("mis_state", 32'(dbg_state), 32'd0);
    chk("mis_rdata", cpu_rdata, model_rdata);
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_state"}, 32'(dbg_state), 32'd0);
    chk({tag, "_rdata"}, cpu_rdata, 32'd0);
    chk({tag, "_req"}, 32'(mem_req), 32'd0);
    chk({tag, "_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_addr"}, mem_addr, 32'd0);
    chk({tag, "_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_err"}, 32'(err_misaligned), 32'd0);
    chk({tag, "_stall"}, 32'(stall), 32'd0);
  endtask

  initial begin
    logic [31:0] a, d, r;
    int kind, ack_at;
    bit stuck;

    // reset with an aligned request present: stall must stay low
    nrst = 1'b1; cpu_read = 1'b1; cpu_write = 1'b0; cpu_addr = 32'h40;
    cpu_wdata = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
    model_rdata = 32'd0;
    @(negedge clk);
    chk("rst_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    cpu_read = 1'b0;
    @(posedge clk); #1;
    nrst = 1'b0;
    @(negedge clk);
    chk_reset_values("rst");
    @(posedge clk); #1;

    // read 0x10, ack in second WAIT cycle -> three stall cycles
    access(1'b1, 1'b0, 32'h10, 32'h0, 32'h1234_5678, 2, 1'b0);
    // write 0x20, immediate ack -> two stall cycles, rdata untouched
    access(1'b0, 1'b1, 32'h20, 32'hCAFE_F00D, 32'h5555_AAAA, 1, 1'b0);
    // read+write together behaves as a write
    access(1'b1, 1'b1, 32'h24, 32'h0BAD_CAFE, 32'h7777_7777, 1, 1'b0);
    misaligned(1'b1, 1'b0, 32'h13);

    // reset while waiting; a stray ack afterwards must be ignored
    cpu_read = 1'b1; cpu_addr = 32'h30;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rw_req", 32'(mem_req), 32'd1);
    @(posedge clk); #1;
    nrst = 1'b1;
    @(negedge clk);
    chk("rw_stall", 32'(stall), 32'd0);
    chk("rw_req_rst", 32'(mem_req), 32'd0);
    @(posedge clk); #1;
    nrst = 1'b0; cpu_read = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hFFFF_0000;
    model_rdata = 32'd0;
    @(negedge clk);
    chk_reset_values("rw");
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(negedge clk);
    chk("rw_no_done", 32'(dbg_state), 32'd0);
    chk("rw_rdata", cpu_rdata, 32'd0);
    @(posedge clk); #1;

    // back-to-back read then write with ack stuck high
    access(1'b1, 1'b0, 32'h100, 32'h0, 32'hA5A5_0001, 1, 1'b1);
    access(1'b0, 1'b1, 32'h104, 32'h1357_9BDF, 32'h0, 1, 1'b1);

`ifdef DMEM_BRIDGE_TIMEOUT_EN
    // no ack: timeout after TO_CYC WAIT cycles
    cpu_read = 1'b1; cpu_addr = 32'h80; mem_ack = 1'b0;
    for (int c = 0; c <= TO_CYC + 1; c++) begin
      @(negedge clk);
      chk("to_stall", 32'(stall), 32'(c <= TO_CYC));
      chk("to_err", 32'(err_timeout), 32'(c == TO_CYC + 1));
      if (c == TO_CYC + 1) chk("to_rdata", cpu_rdata, 32'hDEAD_BEEF);
      @(posedge clk); #1;
    end
    cpu_read = 1'b0;
    model_rdata = 32'hDEAD_BEEF;
`endif

    // randomized accesses with occasional misaligned requests
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      a = a & 32'hFFFF_FFFC;
      d = $urandom;
      r = $urandom;
      kind = $urandom_range(0, 2);
      if (i % 5 == 4) begin
        misaligned(kind != 1, kind != 0, a | 32'($urandom_range(1, 3)));
      end else begin
        stuck  = ($urandom_range(0, 3) == 0);
        ack_at = stuck ? 1 : $urandom_range(1, MAX_ACK);
        access(kind != 1, kind != 0, a, d, r, ack_at, stuck);
      end
    end

    @(negedge clk);
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
